mem_arb2: RTL and testbench

MEM_ARB2 -- requirements
Module: mem_arb2

---
 rtl/mem_arb_pkg.sv | 28 ++
 rtl/rr_arb2.sv | 30 +++
 rtl/mem_arb2.sv | 203 ++++++++++++++++++++
 tb/tb_mem_arb2.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared types and constants for the two-port memory arbiter (mem_arb2)
//   and its round-robin selector (rr_arb2).
//   - NUM_PORTS   : number of requesters (port 0 = fetch, port 1 = data)
//   - port_idx_t  : index of a requester
//   - arb_state_e : transaction FSM states
//   - port_onehot : index -> one-hot requester vector
package mem_arb_pkg;

    localparam int NUM_PORTS = 2;

    typedef logic [$clog2(NUM_PORTS)-1:0] port_idx_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    function automatic logic [NUM_PORTS-1:0] port_onehot(input port_idx_t idx);
        logic [NUM_PORTS-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
//   Combinational two-way round-robin selector.
//   Ports:
//     req       in   per-port request bits
//     last      in   index of the port granted most recently
//     gnt_valid out  at least one request present
//     gnt_idx   out  winning port index (0 when nothing requests)
//   A lone requester always wins; on a tie the port that was not granted
//   last time wins.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  port_idx_t            last,
    output logic                 gnt_valid,
    output port_idx_t            gnt_idx
);

    always_comb begin
        gnt_valid = |req;
        gnt_idx   = '0;
        case (req)
            2'b01:   gnt_idx = port_idx_t'(0);
            2'b10:   gnt_idx = port_idx_t'(1);
            2'b11:   gnt_idx = ~last;
            default: gnt_idx = '0;
        endcase
    end

endmodule

// File: rtl/mem_arb2.sv
// mem_arb2
//   Two-requester memory arbiter with a single outstanding transaction,
//   round-robin arbitration and a per-transaction ready timeout.
//   Ports:
//     clk, rst                  clock, synchronous active-high reset
//     req, write                per-port request / 1=write 0=read
//     addr, wdata, wstrb        per-port command fields
//     rsp_valid, rsp_err        per-port one-cycle completion / timeout pulse
//     rsp_rdata                 shared read data, zero unless rsp_valid
//     mem_addr/wdata/wstrb      memory command fields (valid ISSUE..WAIT)
//     mem_write, mem_read       one-cycle command pulses
//     mem_rdata, mem_ready      memory completion
//     err_sticky                set on any timeout, cleared only by rst
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | no transaction; arbitrate and latch the winner's command
//   ISSUE | mem_read/mem_write pulse high, timeout counter cleared
//   WAIT  | waiting for mem_ready or for the timeout to expire
//   RESP  | rsp_valid (and rsp_err) pulse to the winner, update last-grant
//
//   All outputs come straight from flops, so each output is loaded on the
//   transition into the state in which it must be visible.
module mem_arb2
    import mem_arb_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 1024,
    parameter  int TIMEOUT    = 64,
    localparam int ADDR_WIDTH = $clog2(DEPTH),
    localparam int STRB_WIDTH = DATA_WIDTH / 8,
    localparam int CNT_WIDTH  = $clog2(TIMEOUT + 1)
)
(
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_PORTS-1:0]                  req,
    input  logic [NUM_PORTS-1:0]                  write,
    input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  addr,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  wdata,
    input  logic [NUM_PORTS-1:0][STRB_WIDTH-1:0]  wstrb,
    output logic [NUM_PORTS-1:0]                  rsp_valid,
    output logic [NUM_PORTS-1:0]                  rsp_err,
    output logic [DATA_WIDTH-1:0]                 rsp_rdata,
    output logic [ADDR_WIDTH-1:0]                 mem_addr,
    output logic [DATA_WIDTH-1:0]                 mem_wdata,
    output logic [STRB_WIDTH-1:0]                 mem_wstrb,
    output logic                                  mem_write,
    output logic                                  mem_read,
    input  logic [DATA_WIDTH-1:0]                 mem_rdata,
    input  logic                                  mem_ready,
    output logic                                  err_sticky
);

    arb_state_e state_q, state_d;
    port_idx_t  last_q, last_d;
    port_idx_t  win_q, win_d;
    logic       wr_q, wr_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] cnt_inc;

    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [STRB_WIDTH-1:0] mem_wstrb_q, mem_wstrb_d;
    logic                  mem_write_q, mem_write_d;
    logic                  mem_read_q, mem_read_d;
    logic [NUM_PORTS-1:0]  rsp_valid_q, rsp_valid_d;
    logic [NUM_PORTS-1:0]  rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  err_sticky_q, err_sticky_d;

    logic      gnt_valid;
    port_idx_t gnt_idx;

    rr_arb2 u_rr_arb2 (
        .req       (req),
        .last      (last_q),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    assign cnt_inc = cnt_q + CNT_WIDTH'(1);

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        win_d        = win_q;
        wr_d         = wr_q;
        cnt_d        = cnt_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wstrb_d  = mem_wstrb_q;
        err_sticky_d = err_sticky_q;
        // Pulse outputs default low every cycle.
        mem_write_d  = 1'b0;
        mem_read_d   = 1'b0;
        rsp_valid_d  = '0;
        rsp_err_d    = '0;
        rsp_rdata_d  = '0;

        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    win_d       = gnt_idx;
                    wr_d        = write[gnt_idx];
                    mem_addr_d  = addr[gnt_idx];
                    mem_wdata_d = wdata[gnt_idx];
                    mem_wstrb_d = wstrb[gnt_idx];
                    mem_write_d = write[gnt_idx];
                    mem_read_d  = ~write[gnt_idx];
                    state_d     = ISSUE;
                end else begin
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    mem_wstrb_d = '0;
                end
            end

            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end

            WAIT: begin
                if (mem_ready) begin
                    rsp_valid_d = port_onehot(win_q);
                    // Writes return zero regardless of what the bus shows.
                    rsp_rdata_d = wr_q ? '0 : mem_rdata;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    mem_wstrb_d = '0;
                    state_d     = RESP;
                end else if (cnt_inc == CNT_WIDTH'(TIMEOUT)) begin
                    // TIMEOUT consecutive WAIT cycles without ready.
                    rsp_valid_d  = port_onehot(win_q);
                    rsp_err_d    = port_onehot(win_q);
                    err_sticky_d = 1'b1;
                    mem_addr_d   = '0;
                    mem_wdata_d  = '0;
                    mem_wstrb_d  = '0;
                    cnt_d        = cnt_inc;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            RESP: begin
                last_d  = win_q;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_q       <= port_idx_t'(1);
            win_q        <= '0;
            wr_q         <= 1'b0;
            cnt_q        <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wstrb_q  <= '0;
            mem_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            rsp_valid_q  <= '0;
            rsp_err_q    <= '0;
            rsp_rdata_q  <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            win_q        <= win_d;
            wr_q         <= wr_d;
            cnt_q        <= cnt_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wstrb_q  <= mem_wstrb_d;
            mem_write_q  <= mem_write_d;
            mem_read_q   <= mem_read_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
            rsp_rdata_q  <= rsp_rdata_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wstrb  = mem_wstrb_q;
    assign mem_write  = mem_write_q;
    assign mem_read   = mem_read_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_mem_arb2.sv
// tb_mem_arb2
//   Self-checking bench for mem_arb2: a behavioural memory with programmable
//   latency, per-port drivers fed from command queues, and a monitor that
//   compares every memory command and every response against expectation
//   queues filled by the test sequence.
module tb_mem_arb2;

    localparam int DW    = 32;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;
    localparam int SW    = 4;
    localparam int TO    = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]          req;
    logic [1:0]          write;
    logic [1:0][AW-1:0]  addr;
    logic [1:0][DW-1:0]  wdata;
    logic [1:0][SW-1:0]  wstrb;
    logic [1:0]          rsp_valid;
    logic [1:0]          rsp_err;
    logic [DW-1:0]       rsp_rdata;
    logic [AW-1:0]       mem_addr;
    logic [DW-1:0]       mem_wdata;
    logic [SW-1:0]       mem_wstrb;
    logic                mem_write;
    logic                mem_read;
    logic [DW-1:0]       mem_rdata;
    logic                mem_ready;
    logic                err_sticky;

    logic          model_ready, inj_ready;
    logic [DW-1:0] model_rdata, inj_rdata;
    assign mem_ready = model_ready | inj_ready;
    assign mem_rdata = model_rdata | inj_rdata;

    mem_arb2 #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .write      (write),
        .addr       (addr),
        .wdata      (wdata),
        .wstrb      (wstrb),
        .rsp_valid  (rsp_valid),
        .rsp_err    (rsp_err),
        .rsp_rdata  (rsp_rdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_write  (mem_write),
        .mem_read   (mem_read),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .err_sticky (err_sticky)
    );

    typedef struct {
        logic          wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [SW-1:0] s;
    } cmd_t;

    typedef struct {
        int            port;
        logic [DW-1:0] rdata;
        logic          err;
        int            lat;
    } rsp_t;

    cmd_t stim_q0[$];
    cmd_t stim_q1[$];
    cmd_t exp_cmd_q[$];
    rsp_t exp_rsp_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int mem_lat = 3;
    bit mem_silent = 1'b0;
    int pulse_cnt = 0;
    int last_pulse_cyc = 0;
    int last_rsp_cyc = -100;
    bit outstanding = 1'b0;

    logic [DW-1:0] mem_arr [DEPTH];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Behavioural memory: commands take effect when seen; completion is
    // signalled mem_lat cycles later for exactly one cycle.
    bit            m_pend = 1'b0;
    int            m_wait = 0;
    logic          m_wr = 1'b0;
    logic [AW-1:0] m_addr = '0;

    initial begin : mem_model
        model_ready = 1'b0;
        model_rdata = '0;
        forever begin
            @(negedge clk);
            model_ready = 1'b0;
            model_rdata = '0;
            if (rst) begin
                m_pend = 1'b0;
            end else begin
                if (m_pend) begin
                    m_wait++;
                    if (m_wait == mem_lat) begin
                        model_ready = 1'b1;
                        model_rdata = m_wr ? 32'h5A5A_5A5A : mem_arr[m_addr];
                        m_pend = 1'b0;
                    end
                end
                if (mem_read || mem_write) begin
                    m_wr   = mem_write;
                    m_addr = mem_addr;
                    if (mem_write)
                        for (int b = 0; b < SW; b++)
                            if (mem_wstrb[b]) mem_arr[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
                    m_pend = !mem_silent;
                    m_wait = 0;
                end
            end
        end
    end

    initial begin : monitor
        cmd_t          c;
        rsp_t          r;
        logic [1:0]    oh;
        forever begin
            @(negedge clk);
            if (rst) begin
                outstanding = 1'b0;
                continue;
            end
            if (mem_read || mem_write) begin
                pulse_cnt++;
                chk("cmd_onehot", {63'd0, mem_read & mem_write}, 64'd0);
                chk("cmd_overlap", {63'd0, outstanding}, 64'd0);
                chk("turnaround", {63'd0, (cyc - last_rsp_cyc) >= 2}, 64'd1);
                chk("cmd_expected", {63'd0, exp_cmd_q.size() > 0}, 64'd1);
                if (exp_cmd_q.size() > 0) begin
                    c = exp_cmd_q.pop_front();
                    chk("cmd_write", {63'd0, mem_write}, {63'd0, c.wr});
                    chk("cmd_addr", {54'd0, mem_addr}, {54'd0, c.a});
                    chk("cmd_wdata", {32'd0, mem_wdata}, {32'd0, c.d});
                    chk("cmd_wstrb", {60'd0, mem_wstrb}, {60'd0, c.s});
                end
                outstanding    = 1'b1;
                last_pulse_cyc = cyc;
            end
            if (rsp_valid != 2'b00) begin
                chk("rsp_expected", {63'd0, exp_rsp_q.size() > 0}, 64'd1);
                if (exp_rsp_q.size() > 0) begin
                    r  = exp_rsp_q.pop_front();
                    oh = 2'b01 << r.port;
                    chk("rsp_valid", {62'd0, rsp_valid}, {62'd0, oh});
                    chk("rsp_err", {62'd0, rsp_err}, {62'd0, (r.err ? oh : 2'b00)});
                    chk("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, r.rdata});
                    chk("rsp_latency", 64'(cyc - last_pulse_cyc), 64'(r.lat));
                end
                outstanding  = 1'b0;
                last_rsp_cyc = cyc;
            end else if (rsp_err != 2'b00 || rsp_rdata != '0) begin
                chk("idle_rsp_zero", {30'd0, rsp_err, rsp_rdata}, 64'd0);
            end
        end
    end

    task automatic add(input int p, input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [SW-1:0] s);
        cmd_t c;
        c.wr = wr; c.a = a; c.d = d; c.s = s;
        if (p == 0) stim_q0.push_back(c);
        else        stim_q1.push_back(c);
    endtask

    task automatic expect_txn(input int p, input logic wr, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input logic [SW-1:0] s,
                              input logic [DW-1:0] rdata, input logic err, input int lat);
        cmd_t c;
        rsp_t r;
        c.wr = wr; c.a = a; c.d = d; c.s = s;
        r.port = p; r.rdata = rdata; r.err = err; r.lat = lat;
        exp_cmd_q.push_back(c);
        exp_rsp_q.push_back(r);
    endtask

    // Holds req and fields until this port's rsp_valid, then moves straight
    // on to the next queued command (or drops req).
    task automatic drive_port(input int p);
        cmd_t c;
        int   guard;
        bit   more;
        more = (p == 0) ? (stim_q0.size() > 0) : (stim_q1.size() > 0);
        while (more) begin
            if (p == 0) c = stim_q0.pop_front();
            else        c = stim_q1.pop_front();
            req[p]   = 1'b1;
            write[p] = c.wr;
            addr[p]  = c.a;
            wdata[p] = c.d;
            wstrb[p] = c.s;
            guard = 0;
            do begin
                @(negedge clk);
                guard++;
            end while (rsp_valid[p] !== 1'b1 && guard < 300);
            chk($sformatf("port%0d_done", p), {63'd0, guard < 300}, 64'd1);
            more = (p == 0) ? (stim_q0.size() > 0) : (stim_q1.size() > 0);
        end
        req[p]   = 1'b0;
        write[p] = 1'b0;
        addr[p]  = '0;
        wdata[p] = '0;
        wstrb[p] = '0;
    endtask

    task automatic run_ports(input string tag);
        fork
            drive_port(0);
            drive_port(1);
        join
        repeat (3) @(negedge clk);
        chk({tag, "_rsp_left"}, 64'(exp_rsp_q.size()), 64'd0);
        chk({tag, "_cmd_left"}, 64'(exp_cmd_q.size()), 64'd0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_mem"}, {16'd0, mem_read, mem_write, mem_addr, mem_wdata, mem_wstrb}, 64'd0);
        chk({tag, "_rsp"}, {27'd0, rsp_valid, rsp_err, rsp_rdata, err_sticky}, 64'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int         guard;
        int         pulses0;
        logic [1:0] seen;

        req = '0; write = '0; addr = '0; wdata = '0; wstrb = '0;
        inj_ready = 1'b0; inj_rdata = '0;
        for (int i = 0; i < DEPTH; i++) mem_arr[i] = '0;
        mem_arr[10'h010] = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) mem_arr[10'h030 + i] = 32'hB0B0_0000 + 32'(i);

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        #1 rst = 1'b0;

        // Contention from reset: port0 wins first tie, then port1 wins the
        // next tie while port0 re-requests.
        mem_lat = 3;
        add(0, 1'b1, 10'h020, 32'hCAFE_F00D, 4'hF);
        add(0, 1'b0, 10'h020, 32'h0, 4'h0);
        add(1, 1'b0, 10'h020, 32'h0, 4'h0);
        expect_txn(0, 1'b1, 10'h020, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0, 4);
        expect_txn(1, 1'b0, 10'h020, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, 4);
        expect_txn(0, 1'b0, 10'h020, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, 4);
        run_ports("contention");

        // Single read with 3-cycle memory latency
        add(0, 1'b0, 10'h010, 32'h0, 4'h0);
        expect_txn(0, 1'b0, 10'h010, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 4);
        run_ports("single_read");

        // Back-to-back reads on port1 with minimum memory latency
        mem_lat = 1;
        pulses0 = pulse_cnt;
        for (int i = 0; i < 4; i++) begin
            add(1, 1'b0, AW'(10'h030 + i), 32'h0, 4'h0);
            expect_txn(1, 1'b0, AW'(10'h030 + i), 32'h0, 4'h0, 32'hB0B0_0000 + 32'(i), 1'b0, 2);
        end
        run_ports("b2b");
        chk("b2b_pulses", 64'(pulse_cnt - pulses0), 64'd4);

        // Partial write through byte strobes
        mem_lat = 2;
        add(1, 1'b1, 10'h050, 32'h1122_3344, 4'hF);
        add(1, 1'b1, 10'h050, 32'hAABB_CCDD, 4'h3);
        add(1, 1'b0, 10'h050, 32'h0, 4'h0);
        expect_txn(1, 1'b1, 10'h050, 32'h1122_3344, 4'hF, 32'h0, 1'b0, 3);
        expect_txn(1, 1'b1, 10'h050, 32'hAABB_CCDD, 4'h3, 32'h0, 1'b0, 3);
        expect_txn(1, 1'b0, 10'h050, 32'h0, 4'h0, 32'h1122_CCDD, 1'b0, 3);
        run_ports("partial_write");

        // Timeout: memory never answers
        chk("err_sticky_clear", {63'd0, err_sticky}, 64'd0);
        mem_silent = 1'b1;
        add(0, 1'b0, 10'h040, 32'h0, 4'h0);
        expect_txn(0, 1'b0, 10'h040, 32'h0, 4'h0, 32'h0, 1'b1, TO + 1);
        run_ports("timeout");
        chk("err_sticky_set", {63'd0, err_sticky}, 64'd1);

        // Late ready while idle must be ignored
        inj_ready = 1'b1;
        inj_rdata = 32'h0000_0077;
        @(negedge clk);
        inj_ready = 1'b0;
        inj_rdata = '0;
        seen = 2'b00;
        repeat (4) begin
            @(negedge clk);
            seen = seen | rsp_valid | {mem_read, mem_write};
        end
        chk("stale_ready_ignored", {62'd0, seen}, 64'd0);
        mem_silent = 1'b0;

        // Normal traffic still works; err_sticky stays set
        add(1, 1'b0, 10'h010, 32'h0, 4'h0);
        expect_txn(1, 1'b0, 10'h010, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 3);
        run_ports("post_timeout");
        chk("err_sticky_held", {63'd0, err_sticky}, 64'd1);

        // Reset in the middle of WAIT: no response, outputs cleared
        mem_lat = 6;
        begin
            cmd_t c;
            c.wr = 1'b0; c.a = 10'h033; c.d = '0; c.s = '0;
            exp_cmd_q.push_back(c);
        end
        req[1] = 1'b1; write[1] = 1'b0; addr[1] = 10'h033;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!mem_read && guard < 50);
        chk("rst_wait_issue", {63'd0, guard < 50}, 64'd1);
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        req = '0; addr = '0;
        @(negedge clk);
        chk_outputs_zero("mid_wait_reset");
        #1 rst = 1'b0;
        seen = 2'b00;
        repeat (10) begin
            @(negedge clk);
            seen = seen | rsp_valid;
        end
        chk("no_rsp_after_reset", {62'd0, seen}, 64'd0);

        // Tie after reset goes to port0 again
        mem_lat = 3;
        add(1, 1'b0, 10'h020, 32'h0, 4'h0);
        add(0, 1'b0, 10'h010, 32'h0, 4'h0);
        expect_txn(0, 1'b0, 10'h010, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 4);
        expect_txn(1, 1'b0, 10'h020, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, 4);
        run_ports("tie_after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
